// File: rtl/define_pkg.sv
// Shared types and constants for the SA input feeder.
package DEFINE_PKG;

    localparam int SRAM_ADDR_SIZE  = 10;
    localparam int FEED_SKEW_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } FEED_STATE_t;

endpackage

// File: rtl/FIFO.sv
// Small synchronous FIFO with a fall-through read port and an occupancy count.
module FIFO #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [AW-1:0]           wptr_q, rptr_q;
    logic [CW-1:0]           cnt_q;
    logic                    push_ok, pop_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop_ok)
                rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/sa_input_feeder_skew.sv
// Diagonal skew for the SA input bus: lane j is delayed by j beats.
// Every lane ends in a register, so the outputs are registered.
module sa_feed_skew
    import DEFINE_PKG::*;
#(
    parameter int LANES  = FEED_SKEW_DEPTH + 1,
    parameter int LANE_W = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         adv,
    input  logic [LANES-1:0][LANE_W-1:0] din,
    output logic [LANES-1:0][LANE_W-1:0] dout
);

    genvar j;
    for (j = 0; j < LANES; j++) begin : g_lane
        logic [j:0][LANE_W-1:0] sr_q;

        if (j == 0) begin : g_direct
            // Lane 0 is just the output register.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)  sr_q <= '0;
                else if (adv) sr_q <= din[j];
            end
        end else begin : g_shift
            // Shift one stage per beat; the oldest entry drives the output.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)  sr_q <= '0;
                else if (adv) sr_q <= {sr_q[j-1:0], din[j]};
            end
        end

        assign dout[j] = sr_q[j];
    end

endmodule

// File: rtl/sa_input_feeder.sv
// Streams activation rows from SRAM through a prefetch FIFO into the
// skewed 4-lane input bus of the SA array, then flushes the skew with zeros.
module sa_input_feeder
    import DEFINE_PKG::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_SIZE,
    parameter int DATA_W   = 16,
    parameter int PF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        num_rows,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_rd_addr,
    input  logic              sram_rd_gnt,
    input  logic [DATA_W-1:0] sram_rd_data,
    output logic [3:0][3:0]   feed_in,
    output logic              feed_valid,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(PF_DEPTH) + 1;

    FEED_STATE_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        rows_q, rows_d;
    logic [7:0]        issued_q, issued_d;
    logic [7:0]        popped_q, popped_d;
    logic [1:0]        flush_q, flush_d;
    logic              inflight_q, inflight_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fvalid_q, fvalid_d;

    logic              rd_en, pop, beat;
    logic [3:0][3:0]   skew_din;
    logic [15:0]       fifo_rdata;
    logic              fifo_empty, fifo_full;
    logic [CW-1:0]     fifo_cnt;

    // Prefetch buffer; the read issued last cycle lands here this cycle.
    FIFO #(.W(16), .DEPTH(PF_DEPTH)) u_pf (
        .clk    (clk),
        .resetn (resetn),
        .push   (inflight_q),
        .wdata  (sram_rd_data[15:0]),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .count  (fifo_cnt)
    );

    sa_feed_skew #(.LANES(4), .LANE_W(4)) u_skew (
        .clk    (clk),
        .resetn (resetn),
        .adv    (beat),
        .din    (skew_din),
        .dout   (feed_in)
    );

    // Next-state: job control, read issue, pop and flush sequencing.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rows_d     = rows_q;
        issued_d   = issued_q;
        popped_d   = popped_q;
        flush_d    = flush_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_en      = 1'b0;
        pop        = 1'b0;
        beat       = 1'b0;
        skew_din   = '0;

        // busy drops the cycle after the done pulse.
        if (done_q) busy_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    addr_d   = base_addr;
                    rows_d   = num_rows;
                    issued_d = '0;
                    popped_d = '0;
                    flush_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = (num_rows == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                // Count the in-flight read so the FIFO can never overflow.
                rd_en = (issued_q < rows_q) &&
                        ((int'(fifo_cnt) + int'(inflight_q)) < PF_DEPTH);
                if (rd_en && sram_rd_gnt) begin
                    addr_d   = addr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                end
                // An empty FIFO stalls the skew, which keeps lanes aligned.
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    beat     = 1'b1;
                    skew_din = fifo_rdata;
                    popped_d = popped_q + 1'b1;
                    if (popped_d == rows_q) state_d = FLUSH;
                end
            end
            FLUSH: begin
                beat    = 1'b1;
                flush_d = flush_q + 1'b1;
                if (flush_q == 2'(FEED_SKEW_DEPTH - 1)) state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign inflight_d = rd_en && sram_rd_gnt;
    assign fvalid_d   = beat;

    // State and control registers; reset aborts any running job.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rows_q     <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            flush_q    <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rows_q     <= rows_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            flush_q    <= flush_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fvalid_q   <= fvalid_d;
        end
    end

    assign sram_rd_en   = rd_en;
    assign sram_rd_addr = addr_q;
    assign feed_valid   = fvalid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: doc/sa_input_feeder.md
# sa_input_feeder

- Read-side counterpart of the SA array write-back path.
- Fetches activation rows from SRAM through an arbitrated read port and buffers them in a small prefetch FIFO.
- Applies the systolic diagonal skew and drives the 4-lane, 4-bit `in` bus of the SA array, with a per-beat valid that the controller uses to gate PE enable.
- Tolerates grant stalls without corrupting the skew; flushes the skew pipeline with zero beats at the end of a job.

## Interface
- `ADDR_W`, default `SRAM_ADDR_SIZE`: SRAM address width.
- `DATA_W`, default 16: SRAM read width. Bits [15:0] carry lanes 0..3; higher bits are ignored.
- `PF_DEPTH`, default 4: prefetch FIFO depth. Power of 2, ≥2.
- `clk` in 1: the only clock.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle job request. Ignored while `busy`.
- `base_addr` in ADDR_W: first SRAM word. Sampled on an accepted `start`.
- `num_rows` in 8: rows to stream. Sampled on an accepted `start`. 0 means an empty job.
- `sram_rd_en` out 1: read request.
- `sram_rd_addr` out ADDR_W: read address. Valid while `sram_rd_en` is high.
- `sram_rd_gnt` in 1: arbiter grant, same cycle as the request.
- `sram_rd_data` in DATA_W: read data, valid exactly 1 cycle after a granted request.
- `feed_in` out 4x4 (`[3:0][3:0]`): skewed lane data to the SA array.
- `feed_valid` out 1: the SA array must advance its PEs this cycle.
- `busy` out 1: high from an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the job completes.

## Operation
- Reset value of every output is 0: `sram_rd_en`, `sram_rd_addr`, `feed_in`, `feed_valid`, `busy`, `done`.
- State machine: IDLE, STREAM, FLUSH, DONE.
- IDLE:
  - `start` with `num_rows`≠0 → STREAM; latch the address pointer and the issue/pop counters.
  - `start` with `num_rows`=0 → DONE directly, with no reads issued.
- Read issue (STREAM only):
  - Assert `sram_rd_en` while issued < `num_rows` and FIFO occupancy + in-flight < PF_DEPTH.
  - On `sram_rd_en` & `sram_rd_gnt`: increment the address pointer and the issued count; mark one read in flight.
  - A denied request holds the same address and is retried the next cycle.
- Fill: the in-flight read's `sram_rd_data` is written to the FIFO the following cycle. Lane j = bits [4j+3:4j].
- Pop (STREAM): pop when the FIFO is non-empty.
  - Popped word enters the skew stage.
  - Pop count reaching `num_rows` → FLUSH.
  - FIFO empty → no pop, no skew advance; next `feed_valid`=0 and `feed_in` holds its value.
- FLUSH: inject exactly 3 all-zero beats into the skew stage, one per cycle, then → DONE.
- DONE: pulse `done` for one cycle, drop `busy`, → IDLE.
- Skew: the skew stage advances only on a beat, whether popped or flush.
  - Lane 0 has 0 beats of delay; lane j is delayed by j beats through a per-lane shift register.
  - Output beat k therefore carries lane j of input row k−j, with zeros for k−j<0.
- Total `feed_valid` beats per job = `num_rows` + 3.
- Address arithmetic wraps modulo 2^ADDR_W.
- `resetn` asserted mid-job: the job is aborted immediately.
  - FIFO, skew registers, counters and state all clear.
  - Read data still in flight is discarded.

## Timing
- `start` accepted at cycle 0, `sram_rd_en` first high at cycle 1.
- With continuous grant, first `feed_valid` at cycle 4 (grant at 1, data at 2, pop at 3, registered output at 4).
- Sustained throughput is 1 row/cycle with continuous grant.
- One denied grant cycle adds exactly one `feed_valid`=0 bubble, once the prefetch margin is consumed.
- `done` fires 1 cycle after the last flush beat is visible on `feed_in`.
- `busy` rises at cycle 1 and falls in the cycle after `done`.
- `feed_in` and `feed_valid` are registered outputs; there is no combinational path from `sram_rd_data`.

## Structure
- In `DEFINE_PKG`: enum `FEED_STATE_t` {IDLE, STREAM, FLUSH, DONE} and constant `FEED_SKEW_DEPTH`=3.
- Reuse the existing `FIFO` module for prefetch, with a 16-bit payload and depth PF_DEPTH.
- One new sub-module, `sa_feed_skew`:
  - 4 lanes with per-lane delays 0..3.
  - Advance-enabled.
  - Asynchronous reset.

## Test plan
- `base_addr`=0x010, `num_rows`=4, grant always high, SRAM word n=0x4321+n.
  - Reads at addresses 0x010..0x013.
  - Exactly 7 `feed_valid` beats.
  - Beat 0 `feed_in`={0,0,0,1}; beat 3 lane 3 = 4.
  - `done` at cycle 11.
- Same job, grant low on cycles 2–4.
  - Address 0x011 is held for 3 cycles.
  - `feed_valid` shows bubbles while data is unchanged, with no lane misalignment.
  - Still 7 valid beats.
- `num_rows`=0 → `done` at cycle 2, with no `sram_rd_en` and no `feed_valid`.
- `start` pulsed while `busy` → ignored: the counters and `base_addr` of the running job are unchanged.
- `base_addr`=2^ADDR_W−2, `num_rows`=4 → reads wrap to addresses 0 and 1.
- `resetn` low at cycle 5 of a 10-row job.
  - All outputs 0 in the same cycle.
  - After release, a new job `num_rows`=2 produces exactly 5 beats with no stale data.
